bus_arbiter: RTL and testbench

Sequential arbiter that owns the shared wired-OR datapath bus, granting exactly one source at a time permission to drive it. Sources (ALU, RAM, IO, register file, CP, index unit, offset generator) request the bus; the arbiter issues a registered one-hot grant using round-robin priority, limits hold time, and inserts one idle turnaround cycle between owners. It also flags any source driving the bus without a grant, since OR-combined data silently corrupts in that case.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/rr_pick.sv | 33 +++
 rtl/bus_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants, source indices and FSM state type for the bus arbiter slice.
package bus_pkg;

  localparam int NUM_SRC = 7;
  localparam int IDX_W   = $clog2(NUM_SRC);

  localparam int SRC_ALU    = 0;
  localparam int SRC_RAM    = 1;
  localparam int SRC_IO     = 2;
  localparam int SRC_REGS   = 3;
  localparam int SRC_CP     = 4;
  localparam int SRC_IND    = 5;
  localparam int SRC_OFFSET = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or above rr_ptr, wrapping around.
module rr_pick
  import bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_SRC-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int               sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    sum    = 0;
    pos    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_SRC) sum = sum - NUM_SRC;
      pos = IDX_W'(sum);
      if (!valid && req[pos]) begin
        valid       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the wired-OR datapath bus with hold limit, turnaround
// cycle between owners and a sticky flag for unauthorised drivers.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] lock,
  input  logic [NUM_SRC-1:0] src_active,
  input  logic               err_clr,
  output logic [NUM_SRC-1:0] grant,
  output logic               busy,
  output logic [IDX_W-1:0]   owner,
  output logic               timeout,
  output logic               collision
);

  localparam int               HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_SRC = IDX_W'(NUM_SRC - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               collision_q, collision_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic [NUM_SRC-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               owner_req, owner_lock, hold_done;

  rr_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    owner_req  = req[owner_q];
    owner_lock = lock[owner_q];
    hold_done  = (hold_cnt_q == HOLD_MAX);
    // A new unauthorised driver outranks a clear in the same cycle.
    collision_d = (|(src_active & ~grant_q)) | (collision_q & ~err_clr);

    case (state_q)
      IDLE, TURN: begin
        if (pick_valid) begin
          state_d    = GRANT;
          grant_d    = pick_onehot;
          owner_d    = pick_idx;
          busy_d     = 1'b1;
          hold_cnt_d = HOLD_W'(1);
        end else begin
          state_d    = IDLE;
          grant_d    = '0;
          owner_d    = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!owner_req || !owner_lock || hold_done) begin
          state_d    = TURN;
          grant_d    = '0;
          owner_d    = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          rr_ptr_d   = (owner_q == LAST_SRC) ? '0 : owner_q + 1'b1;
          timeout_d  = owner_req && owner_lock;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      collision_q <= 1'b0;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      collision_q <= collision_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign timeout   = timeout_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenario bench for bus_arbiter: inputs change and outputs are
// sampled on the falling edge, half a cycle after each decision edge.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] req, lock, src_active;
  logic       err_clr;
  logic [6:0] grant;
  logic       busy;
  logic [2:0] owner;
  logic       timeout;
  logic       collision;

  int pass_cnt  = 0;
  int check_cnt = 0;

  bus_arbiter #(.MAX_HOLD(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .lock       (lock),
    .src_active (src_active),
    .err_clr    (err_clr),
    .grant      (grant),
    .busy       (busy),
    .owner      (owner),
    .timeout    (timeout),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; lock = '0; src_active = '0; err_clr = 1'b0;
    tick(); tick();
    check_cnt++;
    if (grant !== 7'b0 || owner !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0 || collision !== 1'b0)
      $display("[TB] FAIL reset_state: grant=%b owner=%0d busy=%b timeout=%b collision=%b, want all zero",
               grant, owner, busy, timeout, collision);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 7'b0000100; lock = '0;
    tick();
    check_cnt++;
    if (grant !== 7'b0000100 || owner !== 3'd2 || busy !== 1'b1)
      $display("[TB] FAIL single_grant: grant=%b owner=%0d busy=%b, want 0000100/2/1", grant, owner, busy);
    else pass_cnt++;
    req = '0;
    tick();
    check_cnt++;
    if (grant !== 7'b0 || busy !== 1'b0 || owner !== 3'd0 || timeout !== 1'b0)
      $display("[TB] FAIL single_turn: grant=%b busy=%b owner=%0d timeout=%b, want idle turn", grant, busy, owner, timeout);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (grant !== 7'b0)
      $display("[TB] FAIL single_idle: grant=%b, want 0000000", grant);
    else pass_cnt++;
  endtask

  // Pointer sits at 3 after src2, so src6 wins first, then strict alternation.
  task automatic test_alternate();
    logic [6:0] exp_g [8];
    logic [2:0] exp_o [8];
    exp_g = '{7'b1000000, 7'b0, 7'b0000001, 7'b0, 7'b1000000, 7'b0, 7'b0000001, 7'b0};
    exp_o = '{3'd6, 3'd0, 3'd0, 3'd0, 3'd6, 3'd0, 3'd0, 3'd0};
    req = 7'b1000001; lock = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_cnt++;
      if (grant !== exp_g[i] || owner !== exp_o[i])
        $display("[TB] FAIL alternate_%0d: grant=%b owner=%0d, want %b/%0d", i, grant, owner, exp_g[i], exp_o[i]);
      else pass_cnt++;
    end
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    int held;
    held = 0;
    req = 7'b0001000; lock = 7'b0001000;
    tick();
    check_cnt++;
    if (owner !== 3'd3)
      $display("[TB] FAIL timeout_owner: owner=%0d, want 3", owner);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      if (grant === 7'b0001000 && timeout === 1'b0) held++;
      if (i < 15) tick();
    end
    check_cnt++;
    if (held !== 16)
      $display("[TB] FAIL timeout_hold_len: held=%0d, want 16", held);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (grant !== 7'b0 || timeout !== 1'b1)
      $display("[TB] FAIL timeout_pulse: grant=%b timeout=%b, want 0000000/1", grant, timeout);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (grant !== 7'b0001000 || timeout !== 1'b0)
      $display("[TB] FAIL timeout_regrant: grant=%b timeout=%b, want 0001000/0", grant, timeout);
    else pass_cnt++;
    req = '0; lock = '0;
    tick();
    check_cnt++;
    if (grant !== 7'b0 || timeout !== 1'b0)
      $display("[TB] FAIL timeout_normal_release: grant=%b timeout=%b, want 0000000/0", grant, timeout);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_collision();
    req = 7'b0000010; lock = 7'b0000010;
    tick();
    check_cnt++;
    if (grant !== 7'b0000010 || collision !== 1'b0)
      $display("[TB] FAIL coll_grant: grant=%b collision=%b, want 0000010/0", grant, collision);
    else pass_cnt++;
    src_active = 7'b0000011;
    tick();
    check_cnt++;
    if (collision !== 1'b1)
      $display("[TB] FAIL coll_set: collision=%b, want 1", collision);
    else pass_cnt++;
    src_active = '0;
    tick(); tick();
    check_cnt++;
    if (collision !== 1'b1)
      $display("[TB] FAIL coll_sticky: collision=%b, want 1", collision);
    else pass_cnt++;
    err_clr = 1'b1; src_active = 7'b0000001;
    tick();
    check_cnt++;
    if (collision !== 1'b1)
      $display("[TB] FAIL coll_set_beats_clr: collision=%b, want 1", collision);
    else pass_cnt++;
    src_active = '0;
    tick();
    check_cnt++;
    if (collision !== 1'b0)
      $display("[TB] FAIL coll_clear: collision=%b, want 0", collision);
    else pass_cnt++;
    err_clr = 1'b0; src_active = 7'b0000010;
    tick();
    check_cnt++;
    if (collision !== 1'b0 || grant !== 7'b0000010)
      $display("[TB] FAIL coll_legal_driver: collision=%b grant=%b, want 0/0000010", collision, grant);
    else pass_cnt++;
    src_active = '0; req = '0; lock = '0;
    tick(); tick();
  endtask

  task automatic test_lock_drop();
    int held;
    held = 0;
    req = 7'b0100000; lock = 7'b0100000;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (grant === 7'b0100000 && owner === 3'd5) held++;
    end
    check_cnt++;
    if (held !== 3)
      $display("[TB] FAIL lockdrop_hold: held=%0d, want 3", held);
    else pass_cnt++;
    req = '0;
    tick();
    check_cnt++;
    if (grant !== 7'b0 || timeout !== 1'b0)
      $display("[TB] FAIL lockdrop_release: grant=%b timeout=%b, want 0000000/0", grant, timeout);
    else pass_cnt++;
    lock = '0;
    tick();
  endtask

  // Pointer is 6 before the reset; only a cleared pointer lets src0 win first.
  task automatic test_reset_mid();
    req = 7'b0100000; lock = 7'b0100000;
    tick();
    check_cnt++;
    if (grant !== 7'b0100000)
      $display("[TB] FAIL rstmid_grant: grant=%b, want 0100000", grant);
    else pass_cnt++;
    tick();
    rst_n = 1'b0;
    tick();
    check_cnt++;
    if (grant !== 7'b0 || owner !== 3'd0 || busy !== 1'b0)
      $display("[TB] FAIL rstmid_drop: grant=%b owner=%0d busy=%b, want 0/0/0", grant, owner, busy);
    else pass_cnt++;
    rst_n = 1'b1; req = 7'b1111111; lock = '0;
    tick();
    check_cnt++;
    if (grant !== 7'b0000001 || owner !== 3'd0 || busy !== 1'b1)
      $display("[TB] FAIL rstmid_src0_first: grant=%b owner=%0d busy=%b, want 0000001/0/1", grant, owner, busy);
    else pass_cnt++;
    tick();
    tick();
    check_cnt++;
    if (grant !== 7'b0000010 || owner !== 3'd1)
      $display("[TB] FAIL rstmid_next_src1: grant=%b owner=%0d, want 0000010/1", grant, owner);
    else pass_cnt++;
    req = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_timeout();
    test_collision();
    test_lock_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
